// File: rtl/doc_pkg.sv
// Shared constants, FSM encodings and cursor command type for the document editor.
// Geometry is fixed at 20 columns by 15 rows, which gives 300 cells.
package doc_pkg;

  localparam int COLS   = 20;
  localparam int ROWS   = 15;
  localparam int DEPTH  = COLS * ROWS;
  localparam int ADDR_W = 9;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);

  localparam logic [7:0] BLANK   = 8'h20;
  localparam logic [7:0] KEY_BS  = 8'h08;
  localparam logic [7:0] KEY_CR  = 8'h0D;
  localparam logic [7:0] KEY_ESC = 8'h1B;

  localparam logic [ADDR_W-1:0] POS_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] POS_DEPTH = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] POS_COLS  = ADDR_W'(COLS);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_INC,
    CUR_DEC,
    CUR_NEWLINE,
    CUR_ZERO
  } cursor_cmd_t;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= 8'h20) && (code <= 8'h7E);
  endfunction

endpackage

// File: rtl/doc_cursor.sv
// Cursor tracker: row and column kept as separate counters next to the linear
// cell index, so no divider is ever needed to locate the cursor.
module doc_cursor
  import doc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  cursor_cmd_t       cmd,
  output logic [ADDR_W-1:0] cursor_pos
);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  // Increment saturates at the last cell; newline on the last row is a no-op.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cursor_pos <= '0;
      row        <= '0;
      col        <= '0;
    end else begin
      case (cmd)
        CUR_INC: begin
          if (cursor_pos != POS_LAST) begin
            cursor_pos <= cursor_pos + ADDR_W'(1);
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        CUR_DEC: begin
          if (cursor_pos != '0) begin
            cursor_pos <= cursor_pos - ADDR_W'(1);
            if (col == '0) begin
              col <= COL_LAST;
              row <= row - ROW_W'(1);
            end else begin
              col <= col - COL_W'(1);
            end
          end
        end
        CUR_NEWLINE: begin
          if (row != ROW_LAST) begin
            row        <= row + ROW_W'(1);
            col        <= '0;
            cursor_pos <= cursor_pos - ADDR_W'(col) + POS_COLS;
          end
        end
        CUR_ZERO: begin
          cursor_pos <= '0;
          row        <= '0;
          col        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/doc_editor.sv
// Key-driven editor owning the write port of the document RAM.
// Blanks the whole document after reset or ESC, then writes one key per two cycles.
module doc_editor
  import doc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  output logic              key_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  output logic [ADDR_W-1:0] cursor_pos,
  output logic              busy
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              accept;
  cursor_cmd_t       cursor_cmd;

  assign accept = (state == ST_IDLE) && key_valid && key_ready;

  // The cursor moves on the same edge that accepts the key.
  always_comb begin
    cursor_cmd = CUR_HOLD;
    if ((state == ST_CLEAR) && (clr_cnt == POS_DEPTH)) begin
      cursor_cmd = CUR_ZERO;
    end else if (accept) begin
      if (is_printable(key_code)) begin
        cursor_cmd = CUR_INC;
      end else if (key_code == KEY_BS) begin
        cursor_cmd = CUR_DEC;
      end else if (key_code == KEY_CR) begin
        cursor_cmd = CUR_NEWLINE;
      end
    end
  end

  doc_cursor u_cursor (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cursor_cmd),
    .cursor_pos (cursor_pos)
  );

  // clr_cnt runs one past the last cell so the final blank write is not
  // overlapped by the cycle in which key_ready rises.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      key_ready <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= BLANK;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == POS_DEPTH) begin
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            key_ready <= 1'b1;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= clr_cnt;
            mem_din  <= BLANK;
            clr_cnt  <= clr_cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          mem_we <= 1'b0;
          if (accept) begin
            key_ready <= 1'b0;
            if (key_code == KEY_ESC) begin
              state   <= ST_CLEAR;
              clr_cnt <= '0;
              busy    <= 1'b1;
            end else begin
              state <= ST_WRITE;
              if (is_printable(key_code)) begin
                mem_we   <= 1'b1;
                mem_addr <= cursor_pos;
                mem_din  <= key_code;
              end else if ((key_code == KEY_BS) && (cursor_pos != '0)) begin
                mem_we   <= 1'b1;
                mem_addr <= cursor_pos - ADDR_W'(1);
                mem_din  <= BLANK;
              end
            end
          end
        end
        ST_WRITE: begin
          state     <= ST_IDLE;
          mem_we    <= 1'b0;
          key_ready <= 1'b1;
        end
        default: begin
          state     <= ST_CLEAR;
          clr_cnt   <= '0;
          key_ready <= 1'b0;
          mem_we    <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_doc_editor.sv
// Scoreboard bench for doc_editor: stimulus queues expected RAM writes and a
// negedge monitor pops and compares them whenever mem_we is high.
module tb_doc_editor;
  import doc_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              key_valid = 1'b0;
  logic [7:0]        key_code = 8'h00;
  logic              key_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic [ADDR_W-1:0] cursor_pos;
  logic              busy;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  doc_editor dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .cursor_pos (cursor_pos),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL write: unexpected write addr %0d din %h", mem_addr, mem_din);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mem_addr !== mon_e.addr) || (mem_din !== mon_e.din)) begin
          errors++;
          $display("[TB] FAIL write: got addr %0d din %h expected addr %0d din %h",
                   mem_addr, mem_din, mon_e.addr, mon_e.din);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pushWrite(input int addr, input logic [7:0] din);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.din  = din;
    exp_q.push_back(e);
  endtask

  task automatic pushClear();
    for (int i = 0; i < DEPTH; i++) pushWrite(i, BLANK);
  endtask

  task automatic waitReady(input string tag, input int budget);
    int n = 0;
    while ((key_ready !== 1'b1) && (n < budget)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, " ready"}, 32'(key_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] code, input bit do_write, input int waddr,
                               input logic [7:0] wdin, input int exp_cursor, input bit timing);
    waitReady("pre-key", 20);
    key_valid = 1'b1;
    key_code  = code;
    if (do_write) pushWrite(waddr, wdin);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    if (code != KEY_ESC) checkOutput("cursor", 32'(cursor_pos), 32'(exp_cursor));
    if (timing) begin
      checkOutput("ready low after accept", 32'(key_ready), 32'd0);
      checkOutput("we after accept", 32'(mem_we), 32'(do_write));
      @(posedge clk);
      #1;
      checkOutput("ready back", 32'(key_ready), 32'd1);
    end
  endtask

  task automatic typeRun(input int from, input int to);
    logic [7:0] c;
    for (int i = from; i < to; i++) begin
      c = 8'h41 + 8'(i % 26);
      applyStimulus(c, 1'b1, i, c, i + 1, 1'b0);
    end
  endtask

  initial begin
    pushClear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("busy during clear", 32'(busy), 32'd1);
    checkOutput("ready during clear", 32'(key_ready), 32'd0);
    waitReady("after reset clear", 400);
    checkOutput("busy after clear", 32'(busy), 32'd0);
    checkOutput("cursor after clear", 32'(cursor_pos), 32'd0);
    checkOutput("clear drained", 32'(exp_q.size()), 32'd0);

    applyStimulus(KEY_BS, 1'b0, 0, 8'h00, 0, 1'b1);
    applyStimulus(8'h41, 1'b1, 0, 8'h41, 1, 1'b1);
    applyStimulus(8'h42, 1'b1, 1, 8'h42, 2, 1'b1);
    typeRun(2, 19);
    applyStimulus(8'h43, 1'b1, 19, 8'h43, 20, 1'b1);
    applyStimulus(KEY_BS, 1'b1, 19, BLANK, 19, 1'b1);
    applyStimulus(KEY_CR, 1'b0, 0, 8'h00, 20, 1'b0);
    typeRun(20, 45);
    applyStimulus(KEY_CR, 1'b0, 0, 8'h00, 60, 1'b1);
    for (int k = 1; k <= 11; k++) applyStimulus(KEY_CR, 1'b0, 0, 8'h00, 60 + 20 * k, 1'b0);
    typeRun(280, 285);
    applyStimulus(KEY_CR, 1'b0, 0, 8'h00, 285, 1'b1);
    typeRun(285, 299);
    applyStimulus(8'h5A, 1'b1, 299, 8'h5A, 299, 1'b1);
    applyStimulus(8'h5A, 1'b1, 299, 8'h5A, 299, 1'b0);
    applyStimulus(8'h01, 1'b0, 0, 8'h00, 299, 1'b1);

    applyStimulus(KEY_ESC, 1'b0, 0, 8'h00, 0, 1'b0);
    pushClear();
    checkOutput("busy after esc", 32'(busy), 32'd1);
    checkOutput("ready after esc", 32'(key_ready), 32'd0);
    begin
      int n = 0;
      while ((exp_q.size() > 150) && (n < 400)) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    checkOutput("mid-clear reached", 32'(exp_q.size() <= 150), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("we in reset", 32'(mem_we), 32'd0);
    exp_q.delete();
    pushClear();
    waitReady("after restarted clear", 400);
    checkOutput("cursor after restart", 32'(cursor_pos), 32'd0);
    checkOutput("restart drained", 32'(exp_q.size()), 32'd0);

    applyStimulus(8'h51, 1'b1, 0, 8'h51, 1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("final drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/doc_editor.md
Name: doc_editor

Overview:
- Upstream stage of the text display path. Owns the 20x15 character document RAM write port (a/d/we side of the dual-port doc memory); the display stage reads the same RAM through dpra.
- Accepts ASCII key codes over a valid/ready handshake and maintains a cursor.
- Writes characters, handles backspace, newline and clear, and blanks the whole document after reset.

Parameters:
- COLS, 20, characters per row
- ROWS, 15, rows per document
- DEPTH, 300, COLS*ROWS cells
- ADDR_W, 9, doc address width
- BLANK, 8'h20, fill character (space)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- key_valid  in  1  key_code valid
- key_code  in  8  ASCII code
- key_ready  out  1  block can accept a key this cycle
- mem_addr  out  ADDR_W  doc RAM write address (to a)
- mem_din  out  8  doc RAM write data (to d)
- mem_we  out  1  doc RAM write enable (to we)
- cursor_pos  out  ADDR_W  current cursor cell, row*COLS+col
- busy  out  1  clear sequence in progress

Behaviour:
- Reset: rst==0 sampled at a clk edge forces state CLEAR with clr_cnt=0, cursor_pos=0, key_ready=0, mem_we=0, mem_addr=0, mem_din=BLANK, busy=1. Reset mid-clear or mid-write restarts the clear from 0.
- FSM states: CLEAR, IDLE, WRITE. All outputs are registered.
- CLEAR:
  - Each cycle drives mem_we=1, mem_addr=clr_cnt, mem_din=BLANK, then increments clr_cnt.
  - After addr DEPTH-1 is written, go to IDLE with busy=0 and cursor_pos=0.
  - Total 300 write cycles; key_ready=0 throughout.
- IDLE:
  - key_ready=1, mem_we=0.
  - Handshake: a key is accepted on the edge where key_valid&&key_ready. The key is decoded at that edge and the state moves to WRITE, except for ESC, which moves to CLEAR.
  - Unaccepted keys are not dropped by the block; the source holds key_valid.
- WRITE: lasts exactly one cycle, key_ready=0; mem_we, mem_addr and mem_din hold the decoded write; returns to IDLE. Throughput is one key per 2 cycles.
- Decode (applied at the accept edge; cursor updated at the same edge):
  - Printable 0x20..0x7E: write code at cursor_pos. cursor_pos+1, saturating at DEPTH-1. A write at 299 overwrites cell 299 and the cursor stays.
  - Backspace 0x08, cursor>0: cursor_pos-1, then write BLANK at the new position.
  - Backspace 0x08, cursor==0: no write (mem_we stays 0 in WRITE), cursor unchanged.
  - Enter 0x0D: cursor_pos = (row+1)*COLS, no write. On the last row (row==ROWS-1) the cursor is unchanged.
  - ESC 0x1B: go to CLEAR (clr_cnt=0, busy=1). The cursor returns to 0 at the end of the clear.
  - Any other code: accepted, ignored, no write, cursor unchanged, still passes through WRITE.
- Row/col: row = cursor_pos / COLS and col = cursor_pos % COLS, kept as separate registers, never computed with a divider. Wrap from col COLS-1 to col 0 of the next row on increment; the reverse on decrement.
- Width: all address arithmetic is ADDR_W bits; row*COLS must never exceed DEPTH-1.
- key_valid during CLEAR or WRITE: ignored (key_ready=0).

Decomposition:
- Shared package doc_pkg: COLS, ROWS, DEPTH, ADDR_W, BLANK, ASCII constants (KEY_BS=8'h08, KEY_CR=8'h0D, KEY_ESC=8'h1B), state enum.
- One natural sub-module: doc_cursor, which holds row/col counters with inc/dec/newline/zero commands and outputs cursor_pos. doc_editor holds the FSM, decode and write port.

Test Plan:
- Reset: rst low 1 cycle, then high -> exactly 300 consecutive mem_we pulses at addr 0..299 with din 0x20; then busy=0, key_ready=1, cursor_pos=0.
- After clear, send 'A'(0x41), 'B'(0x42) -> writes (0,0x41) and (1,0x42), each one cycle after accept; cursor_pos=2; key_ready low exactly 1 cycle after each accept.
- Cursor 19, send 0x43 -> write addr 19; cursor_pos=20 (row 1, col 0). Then 0x08 -> write BLANK at addr 19; cursor_pos=19.
- Cursor 0, send 0x08 -> no mem_we; cursor 0. Cursor 45, send 0x0D -> cursor 60, no write. Cursor 285, send 0x0D -> cursor stays 285.
- Cursor 299, send 0x5A twice -> both write addr 299; cursor stays 299. Send 0x01 -> no write, cursor unchanged.
- Send ESC at cursor 123, then assert rst low at clear cycle 150 -> clear restarts from addr 0; 300 full writes complete; cursor_pos=0.
